// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep controller: FSM state encoding and direction levels.
// Dwell states are present only when SWEEP_CTRL_DWELL_EN is defined.
package sweep_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

`ifdef SWEEP_CTRL_DWELL_EN
    typedef enum logic [2:0] {
        IDLE,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO
    } sweep_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        UP,
        DOWN
    } sweep_state_t;
`endif

endpackage

// File: rtl/sweep_ctrl_ud_counter.sv
// Modulo-M up/down counter with synchronous reset, enable and synchronous load-zero.
module ud_counter
    import sweep_pkg::*;
#(
    parameter int M = 32,
    parameter int N = $clog2(M)
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic         en_i,
    input  logic         up_down_i,
    input  logic         clr_i,
    output logic [N-1:0] count_o
);

    localparam logic [N-1:0] CNT_MAX = N'(M - 1);

    logic [N-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            if (up_down_i == DIR_UP) begin
                count_q <= (count_q == CNT_MAX) ? '0 : count_q + N'(1);
            end else begin
                count_q <= (count_q == '0) ? CNT_MAX : count_q - N'(1);
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sweep_ctrl.sv
// Triangle sweep controller: counts 0..M-1..0 for REPS sweeps, with hold, abort and
// optional endpoint dwell (enable with macro SWEEP_CTRL_DWELL_EN, length set by DWELL).
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int M      = 32,
    parameter int N      = $clog2(M),
    parameter int REPS_W = 4
`ifdef SWEEP_CTRL_DWELL_EN
    ,
    parameter int DWELL  = 4
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              HOLD,
    input  logic [REPS_W-1:0] REPS,
    output logic [N-1:0]      COUNT,
    output logic              DIR,
    output logic              BUSY,
    output logic              DONE,
    output logic [REPS_W-1:0] SWEEP,
    output logic              TC
);

    localparam logic [N-1:0] CNT_MAX = N'(M - 1);

    sweep_state_t      state_q;
    logic              dir_q;
    logic              busy_q;
    logic              done_q;
    logic [REPS_W-1:0] sweep_q;
    logic [REPS_W-1:0] reps_q;
    logic [N-1:0]      count;
    logic              cnt_en;
    logic              cnt_up;
    logic              cnt_clr;
    logic              tc;
    logic              last_sweep;
    logic              start_ok;

`ifdef SWEEP_CTRL_DWELL_EN
    localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;
    logic [TW-1:0] timer_q;
`endif

    assign last_sweep = (sweep_q == reps_q - REPS_W'(1));
    assign start_ok   = START && (REPS != '0);

    // Counter steering: the counter moves on the same edge the FSM changes state,
    // so reversal at an endpoint is expressed as a flipped direction, not a pause.
    always_comb begin
        cnt_en  = 1'b0;
        cnt_up  = DIR_UP;
        cnt_clr = ABORT || (!HOLD && state_q == IDLE && start_ok);
        tc      = 1'b0;
        if (!HOLD && !ABORT) begin
            case (state_q)
                UP: begin
                    cnt_en = 1'b1;
                    if (count == CNT_MAX) begin
                        tc = 1'b1;
`ifdef SWEEP_CTRL_DWELL_EN
                        cnt_en = 1'b0;
`else
                        cnt_up = DIR_DOWN;
`endif
                    end
                end
                DOWN: begin
                    cnt_en = 1'b1;
                    cnt_up = DIR_DOWN;
                    if (count == '0) begin
                        tc = 1'b1;
`ifdef SWEEP_CTRL_DWELL_EN
                        cnt_en = 1'b0;
`else
                        cnt_en = !last_sweep;
                        cnt_up = DIR_UP;
`endif
                    end
                end
`ifdef SWEEP_CTRL_DWELL_EN
                DWELL_HI: begin
                    cnt_en = (timer_q == '0);
                    cnt_up = DIR_DOWN;
                end
                DWELL_LO: begin
                    cnt_en = (timer_q == '0);
                    cnt_up = DIR_UP;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sweep_q <= '0;
            reps_q  <= '0;
`ifdef SWEEP_CTRL_DWELL_EN
            timer_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (ABORT) begin
                state_q <= IDLE;
                dir_q   <= DIR_UP;
                busy_q  <= 1'b0;
                sweep_q <= '0;
            end else if (!HOLD) begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            state_q <= UP;
                            reps_q  <= REPS;
                            sweep_q <= '0;
                            dir_q   <= DIR_UP;
                            busy_q  <= 1'b1;
                        end
                    end
                    UP: begin
                        if (count == CNT_MAX) begin
`ifdef SWEEP_CTRL_DWELL_EN
                            state_q <= DWELL_HI;
                            timer_q <= TW'(DWELL - 1);
`else
                            state_q <= DOWN;
                            dir_q   <= DIR_DOWN;
`endif
                        end
                    end
                    DOWN: begin
                        if (count == '0) begin
                            if (last_sweep) begin
                                state_q <= IDLE;
                                dir_q   <= DIR_UP;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                sweep_q <= '0;
                            end else begin
                                sweep_q <= sweep_q + REPS_W'(1);
`ifdef SWEEP_CTRL_DWELL_EN
                                state_q <= DWELL_LO;
                                timer_q <= TW'(DWELL - 1);
`else
                                state_q <= UP;
                                dir_q   <= DIR_UP;
`endif
                            end
                        end
                    end
`ifdef SWEEP_CTRL_DWELL_EN
                    DWELL_HI: begin
                        if (timer_q == '0) begin
                            state_q <= DOWN;
                            dir_q   <= DIR_DOWN;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
                    DWELL_LO: begin
                        if (timer_q == '0) begin
                            state_q <= UP;
                            dir_q   <= DIR_UP;
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    ud_counter #(
        .M (M),
        .N (N)
    ) u_counter (
        .clk_i     (CLK),
        .srst_i    (RST),
        .en_i      (cnt_en),
        .up_down_i (cnt_up),
        .clr_i     (cnt_clr),
        .count_o   (count)
    );

    assign COUNT = count;
    assign DIR   = dir_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign SWEEP = sweep_q;
    assign TC    = tc;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 The block SHALL have parameter M, default 32, meaning counter modulus (M>=2).
REQ-002 The block SHALL have parameter N, default $clog2(M), meaning COUNT width.
REQ-003 The block SHALL have parameter REPS_W, default 4, meaning width of REPS and SWEEP.
REQ-004 The block SHALL have parameter DWELL, default 4, meaning endpoint hold cycles (used only with SWEEP_CTRL_DWELL_EN, DWELL>=1).
REQ-005 The block SHALL have port CLK, input, 1, the single clock; all logic on rising edge.
REQ-006 The block SHALL have port RST, input, 1, reset; it is synchronous and active-high.
REQ-007 The block SHALL have port START, input, 1, the sweep request.
REQ-008 The block SHALL have port ABORT, input, 1, which terminates any operation.
REQ-009 The block SHALL have port HOLD, input, 1, which freezes progress.
REQ-010 The block SHALL have port REPS, input, REPS_W, the number of full sweeps.
REQ-011 The block SHALL have port COUNT, output, N, the current counter value.
REQ-012 The block SHALL have port DIR, output, 1, where 1 means up and 0 means down.
REQ-013 The block SHALL have port BUSY, output, 1, high in any non-IDLE state.
REQ-014 The block SHALL have port DONE, output, 1, a one-cycle completion pulse.
REQ-015 The block SHALL have port SWEEP, output, REPS_W, the index of the current sweep.
REQ-016 The block SHALL have port TC, output, 1, high when COUNT is at an endpoint and the counter advances.

Function
REQ-017 The block SHALL implement FSM states IDLE, UP, DWELL_HI, DOWN, DWELL_LO; DWELL_HI and DWELL_LO exist only with the macro.
REQ-018 The block SHALL leave IDLE for UP on START=1 with REPS!=0, latching REPS and setting COUNT=0, SWEEP=0, DIR=1 in the next cycle.
REQ-019 The block SHALL ignore START when REPS==0 or when BUSY=1.
REQ-020 The block SHALL increment COUNT by 1 per cycle in UP and decrement it by 1 per cycle in DOWN, modulo M, with no wrap occurring in normal sequencing.
REQ-021 From UP at COUNT==M-1, the block SHALL assert TC and enter DOWN (or DWELL_HI with the macro); with no dwell, the next COUNT SHALL be M-2.
REQ-022 From DOWN at COUNT==0, the block SHALL assert TC; if SWEEP==latched REPS-1 it SHALL go to IDLE and pulse DONE in that transition cycle+1, otherwise it SHALL increment SWEEP and enter UP (or DWELL_LO).
REQ-023 One sweep without dwell SHALL last 2M-2 cycles, with endpoint values shown for one cycle each.
REQ-024 With HOLD=1, state, COUNT, SWEEP, DIR and the dwell timer SHALL be frozen, and TC SHALL be forced to 0.
REQ-025 With ABORT=1, the next cycle SHALL have state IDLE, COUNT=0, DIR=1 and SWEEP=0 with no DONE; ABORT SHALL override HOLD and START.
REQ-026 Changes of REPS while BUSY SHALL have no effect.

Reset
REQ-027 On RST=1 at a clock edge, the block SHALL set state=IDLE, COUNT=0, DIR=1, BUSY=0, DONE=0, TC=0 and SWEEP=0; RST SHALL override all inputs, including mid-sweep.

Configuration
REQ-028 With macro SWEEP_CTRL_DWELL_EN defined, the block SHALL hold COUNT at the endpoint for DWELL extra cycles in DWELL_HI/DWELL_LO, with BUSY=1 and TC=0 while dwelling, before reversing direction.
REQ-029 Without SWEEP_CTRL_DWELL_EN, the dwell states, the dwell timer and DWELL SHALL be absent and reversal SHALL be immediate.

Structure
REQ-030 A shared package sweep_pkg SHALL hold the state enumeration typedef and the DIR_UP/DIR_DOWN constants.
REQ-031 The counter SHALL be a sub-module ud_counter (synchronous reset, EN, UP_DOWN, load-zero), instantiated once; the FSM drives its EN and UP_DOWN.

Verification (M=4, REPS_W=4, no macro unless stated)
REQ-032 START with REPS=1 -> COUNT 0,1,2,3,2,1,0, TC at COUNT=3 and at the final 0, then DONE for 1 cycle and BUSY=0.
REQ-033 START with REPS=2 -> SWEEP changes 0→1 after the first return to 0, COUNT continues 1,2,3…; a single DONE after the second sweep.
REQ-034 HOLD=1 for 3 cycles at COUNT=2 going up -> COUNT stays at 2 for 3 cycles, then 3.
REQ-035 ABORT at COUNT=3 -> next cycle IDLE, COUNT=0, no DONE; START with REPS=0 -> BUSY stays 0.
REQ-036 RST asserted mid-DOWN together with START -> all outputs at reset values next cycle.
REQ-037 With SWEEP_CTRL_DWELL_EN and DWELL=2 -> COUNT=3 held for 3 cycles total and COUNT=0 between sweeps held for 3 cycles.
